// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response and memory-side signals of the unified memory port.
// slave = arbiter; master = core and memory macro.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;

    modport slave (
        input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_en, mem_wr, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_en, mem_wr, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data normally wins; a saturating streak counter bounds fetch starvation.
//
// state  | meaning
// IDLE   | memory free, arbitrate pending requests
// ACCESS | granted access in flight for WAIT_CYC+1 cycles
// RESP   | one-cycle ready pulse to the granted requester
module mem_port_arbiter #(
    parameter int WAIT_CYC   = 1,
    parameter int MAX_DBURST = 4
) (
    input logic clk,
    input logic nrst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] WAIT_LIM  = 4'(WAIT_CYC);
    localparam logic [3:0] BURST_LIM = 4'(MAX_DBURST);

    state_t      state, state_nxt;
    logic        gnt_d, gnt_d_nxt;
    logic [3:0]  wcnt, wcnt_nxt;
    logic [3:0]  dstreak, dstreak_nxt;
    logic        mem_en_q, mem_en_nxt;
    logic        mem_wr_q, mem_wr_nxt;
    logic [31:0] mem_addr_q, mem_addr_nxt;
    logic [31:0] mem_wdata_q, mem_wdata_nxt;
    logic        if_ready_q, if_ready_nxt;
    logic        d_ready_q, d_ready_nxt;
    logic [31:0] if_rdata_q, if_rdata_nxt;
    logic [31:0] d_rdata_q, d_rdata_nxt;
    logic        grant_d, grant_i;

    assign grant_d = bus.d_req & (~bus.if_req | (dstreak < BURST_LIM));
    assign grant_i = bus.if_req & ~grant_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            gnt_d       <= 1'b0;
            wcnt        <= 4'd0;
            dstreak     <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state       <= state_nxt;
            gnt_d       <= gnt_d_nxt;
            wcnt        <= wcnt_nxt;
            dstreak     <= dstreak_nxt;
            mem_en_q    <= mem_en_nxt;
            mem_wr_q    <= mem_wr_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            if_ready_q  <= if_ready_nxt;
            d_ready_q   <= d_ready_nxt;
            if_rdata_q  <= if_rdata_nxt;
            d_rdata_q   <= d_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        gnt_d_nxt     = gnt_d;
        wcnt_nxt      = wcnt;
        dstreak_nxt   = dstreak;
        mem_en_nxt    = mem_en_q;
        mem_wr_nxt    = mem_wr_q;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;
        if_ready_nxt  = 1'b0;
        d_ready_nxt   = 1'b0;
        if_rdata_nxt  = if_rdata_q;
        d_rdata_nxt   = d_rdata_q;

        unique case (state)
            IDLE: begin
                if (grant_d | grant_i) begin
                    state_nxt    = ACCESS;
                    gnt_d_nxt    = grant_d;
                    wcnt_nxt     = 4'd0;
                    mem_en_nxt   = 1'b1;
                    mem_wr_nxt   = grant_d & bus.d_wr;
                    mem_addr_nxt = grant_d ? bus.d_addr : bus.if_addr;
                    if (grant_d) begin
                        mem_wdata_nxt = bus.d_wdata;
                    end
                    // streak only grows while a fetch is actually being held off
                    if (grant_d & bus.if_req) begin
                        dstreak_nxt = (dstreak == 4'hF) ? dstreak : dstreak + 4'd1;
                    end else begin
                        dstreak_nxt = 4'd0;
                    end
                end
            end
            ACCESS: begin
                wcnt_nxt = wcnt + 4'd1;
                if (wcnt == WAIT_LIM) begin
                    state_nxt  = RESP;
                    mem_en_nxt = 1'b0;
                    mem_wr_nxt = 1'b0;
                    if (gnt_d) begin
                        d_ready_nxt = 1'b1;
                        if (!mem_wr_q) begin
                            d_rdata_nxt = bus.mem_rdata;
                        end
                    end else begin
                        if_ready_nxt = 1'b1;
                        if_rdata_nxt = bus.mem_rdata;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.d_req & ~d_ready_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand sequences
// for starvation bound, reset mid-store and zero wait states.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic nrst_a, nrst_b;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus_a();
    mem_port_arbiter_if bus_b();

    mem_port_arbiter #(.WAIT_CYC(1), .MAX_DBURST(4)) u_a (.clk(clk), .nrst(nrst_a), .bus(bus_a));
    mem_port_arbiter #(.WAIT_CYC(0), .MAX_DBURST(4)) u_b (.clk(clk), .nrst(nrst_b), .bus(bus_b));

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] mrd;
        logic        e_en;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_ifr;
        logic [31:0] e_ifd;
        logic        e_dr;
        logic [31:0] e_dd;
        logic        e_stall;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endfunction

    task automatic drive_a(vec_t v);
        bus_a.if_req    = v.ir;
        bus_a.if_addr   = v.ia;
        bus_a.d_req     = v.dr;
        bus_a.d_wr      = v.dw;
        bus_a.d_addr    = v.da;
        bus_a.d_wdata   = v.dwd;
        bus_a.mem_rdata = v.mrd;
    endtask

    task automatic cmp_row(int i, vec_t v);
        chk($sformatf("row%0d mem_en", i),    32'(bus_a.mem_en),   32'(v.e_en));
        chk($sformatf("row%0d mem_wr", i),    32'(bus_a.mem_wr),   32'(v.e_wr));
        chk($sformatf("row%0d mem_addr", i),  bus_a.mem_addr,      v.e_addr);
        chk($sformatf("row%0d mem_wdata", i), bus_a.mem_wdata,     v.e_wdata);
        chk($sformatf("row%0d if_ready", i),  32'(bus_a.if_ready), 32'(v.e_ifr));
        chk($sformatf("row%0d if_rdata", i),  bus_a.if_rdata,      v.e_ifd);
        chk($sformatf("row%0d d_ready", i),   32'(bus_a.d_ready),  32'(v.e_dr));
        chk($sformatf("row%0d d_rdata", i),   bus_a.d_rdata,       v.e_dd);
        chk($sformatf("row%0d stall", i),     32'(bus_a.stall),    32'(v.e_stall));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int  n_dg;
        int  c;
        bit  seen_f, done, prev_en, any_rdy;

        // fields: ir ia dr dw da dwd mrd | en wr addr wdata ifr ifd dr dd stall
        // fetch of 0x40
        vecs[0]  = '{1'b0,32'h0 ,1'b0,1'b0,32'h0  ,32'h0       ,32'h0       , 1'b0,1'b0,32'h0  ,32'h0       ,1'b0,32'h0       ,1'b0,32'h0       ,1'b0};
        vecs[1]  = '{1'b1,32'h40,1'b0,1'b0,32'h0  ,32'h0       ,32'h0       , 1'b0,1'b0,32'h0  ,32'h0       ,1'b0,32'h0       ,1'b0,32'h0       ,1'b1};
        vecs[2]  = '{1'b1,32'h40,1'b0,1'b0,32'h0  ,32'h0       ,32'hBAD0BAD0, 1'b1,1'b0,32'h40 ,32'h0       ,1'b0,32'h0       ,1'b0,32'h0       ,1'b1};
        vecs[3]  = '{1'b1,32'h40,1'b0,1'b0,32'h0  ,32'h0       ,32'h2008000A, 1'b1,1'b0,32'h40 ,32'h0       ,1'b0,32'h0       ,1'b0,32'h0       ,1'b1};
        vecs[4]  = '{1'b1,32'h40,1'b0,1'b0,32'h0  ,32'h0       ,32'h0       , 1'b0,1'b0,32'h40 ,32'h0       ,1'b1,32'h2008000A,1'b0,32'h0       ,1'b0};
        // store to 0x100; request fields change mid-access
        vecs[5]  = '{1'b0,32'h0 ,1'b1,1'b1,32'h100,32'hDEADBEEF,32'h0       , 1'b0,1'b0,32'h40 ,32'h0       ,1'b0,32'h2008000A,1'b0,32'h0       ,1'b1};
        vecs[6]  = '{1'b0,32'h0 ,1'b1,1'b1,32'h200,32'h11111111,32'h55555555, 1'b1,1'b1,32'h100,32'hDEADBEEF,1'b0,32'h2008000A,1'b0,32'h0       ,1'b1};
        vecs[7]  = '{1'b0,32'h0 ,1'b1,1'b1,32'h200,32'h11111111,32'h55555555, 1'b1,1'b1,32'h100,32'hDEADBEEF,1'b0,32'h2008000A,1'b0,32'h0       ,1'b1};
        vecs[8]  = '{1'b0,32'h0 ,1'b1,1'b1,32'h100,32'hDEADBEEF,32'h0       , 1'b0,1'b0,32'h100,32'hDEADBEEF,1'b0,32'h2008000A,1'b1,32'h0       ,1'b0};
        vecs[9]  = '{1'b0,32'h0 ,1'b0,1'b0,32'h0  ,32'h0       ,32'h0       , 1'b0,1'b0,32'h100,32'hDEADBEEF,1'b0,32'h2008000A,1'b0,32'h0       ,1'b0};
        // contention: load 0x80 wins, fetch 0x44 follows
        vecs[10] = '{1'b1,32'h44,1'b1,1'b0,32'h80 ,32'h0       ,32'h0       , 1'b0,1'b0,32'h100,32'hDEADBEEF,1'b0,32'h2008000A,1'b0,32'h0       ,1'b1};
        vecs[11] = '{1'b1,32'h44,1'b1,1'b0,32'h80 ,32'h0       ,32'h0       , 1'b1,1'b0,32'h80 ,32'h0       ,1'b0,32'h2008000A,1'b0,32'h0       ,1'b1};
        vecs[12] = '{1'b1,32'h44,1'b1,1'b0,32'h80 ,32'h0       ,32'hCAFE0001, 1'b1,1'b0,32'h80 ,32'h0       ,1'b0,32'h2008000A,1'b0,32'h0       ,1'b1};
        vecs[13] = '{1'b1,32'h44,1'b0,1'b0,32'h0  ,32'h0       ,32'h0       , 1'b0,1'b0,32'h80 ,32'h0       ,1'b0,32'h2008000A,1'b1,32'hCAFE0001,1'b1};
        vecs[14] = '{1'b1,32'h44,1'b0,1'b0,32'h0  ,32'h0       ,32'h0       , 1'b0,1'b0,32'h80 ,32'h0       ,1'b0,32'h2008000A,1'b0,32'hCAFE0001,1'b1};
        vecs[15] = '{1'b1,32'h44,1'b0,1'b0,32'h0  ,32'h0       ,32'h0       , 1'b1,1'b0,32'h44 ,32'h0       ,1'b0,32'h2008000A,1'b0,32'hCAFE0001,1'b1};
        vecs[16] = '{1'b1,32'h44,1'b0,1'b0,32'h0  ,32'h0       ,32'h8C220004, 1'b1,1'b0,32'h44 ,32'h0       ,1'b0,32'h2008000A,1'b0,32'hCAFE0001,1'b1};
        vecs[17] = '{1'b0,32'h0 ,1'b0,1'b0,32'h0  ,32'h0       ,32'h0       , 1'b0,1'b0,32'h44 ,32'h0       ,1'b1,32'h8C220004,1'b0,32'hCAFE0001,1'b0};
        vecs[18] = '{1'b0,32'h0 ,1'b0,1'b0,32'h0  ,32'h0       ,32'h0       , 1'b0,1'b0,32'h44 ,32'h0       ,1'b0,32'h8C220004,1'b0,32'hCAFE0001,1'b0};

        nrst_a = 1'b0;
        nrst_b = 1'b0;
        drive_a(vecs[0]);
        bus_b.if_req = 1'b0; bus_b.if_addr = 32'h0; bus_b.d_req = 1'b0; bus_b.d_wr = 1'b0;
        bus_b.d_addr = 32'h0; bus_b.d_wdata = 32'h0; bus_b.mem_rdata = 32'h0;

        #12;
        chk("reset a state",   32'(u_a.state),   32'd0);
        chk("reset a gnt_d",   32'(u_a.gnt_d),   32'd0);
        chk("reset a dstreak", 32'(u_a.dstreak), 32'd0);
        chk("reset b mem_en",  32'(bus_b.mem_en), 32'd0);
        chk("reset b d_ready", 32'(bus_b.d_ready), 32'd0);
        nrst_a = 1'b1;
        nrst_b = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            drive_a(vecs[i]);
            @(negedge clk);
            cmp_row(i, vecs[i]);
            @(posedge clk); #1;
        end

        // starvation bound: fetch held against continuous data requests
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h48;
        bus_a.d_req = 1'b1; bus_a.d_wr = 1'b0; bus_a.d_addr = 32'h90; bus_a.mem_rdata = 32'h0;
        n_dg = 0; seen_f = 1'b0; done = 1'b0; prev_en = 1'b0; c = 0;
        while (c < 60 && !done) begin
            @(negedge clk);
            if (bus_a.mem_en && !prev_en) begin
                if (bus_a.mem_addr == 32'h48) seen_f = 1'b1;
                else if (!seen_f) n_dg++;
            end
            prev_en = bus_a.mem_en;
            if (bus_a.if_ready) begin
                bus_a.if_req = 1'b0;
                bus_a.d_req  = 1'b0;
                done = 1'b1;
            end
            @(posedge clk); #1;
            c++;
        end
        chk("starve fetch completed", 32'(done), 32'd1);
        chk("starve fetch granted",   32'(seen_f), 32'd1);
        chk("starve data grants",     32'(n_dg), 32'd4);
        chk("starve dstreak cleared", 32'(u_a.dstreak), 32'd0);

        // reset during the second ACCESS cycle of a store
        bus_a.d_req = 1'b1; bus_a.d_wr = 1'b1; bus_a.d_addr = 32'h300; bus_a.d_wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid-store mem_wr before reset", 32'(bus_a.mem_wr), 32'd1);
        chk("mid-store wcnt before reset",   32'(u_a.wcnt), 32'd1);
        #2 nrst_a = 1'b0;
        #1;
        chk("rst mem_wr",    32'(bus_a.mem_wr),   32'd0);
        chk("rst mem_en",    32'(bus_a.mem_en),   32'd0);
        chk("rst d_ready",   32'(bus_a.d_ready),  32'd0);
        chk("rst mem_addr",  bus_a.mem_addr,      32'd0);
        chk("rst mem_wdata", bus_a.mem_wdata,     32'd0);
        chk("rst if_rdata",  bus_a.if_rdata,      32'd0);
        chk("rst d_rdata",   bus_a.d_rdata,       32'd0);
        chk("rst gnt_d",     32'(u_a.gnt_d),      32'd0);
        chk("rst wcnt",      32'(u_a.wcnt),       32'd0);
        chk("rst state",     32'(u_a.state),      32'd0);
        chk("rst stall follows d_req", 32'(bus_a.stall), 32'd1);
        bus_a.d_req = 1'b0;
        @(negedge clk);
        nrst_a = 1'b1;
        any_rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus_a.d_ready || bus_a.mem_en) any_rdy = 1'b1;
        end
        chk("post-reset no access/ready", 32'(any_rdy), 32'd0);
        chk("post-reset state idle",      32'(u_a.state), 32'd0);

        // zero wait states: load from 0x8
        @(posedge clk); #1;
        bus_b.d_req = 1'b1; bus_b.d_wr = 1'b0; bus_b.d_addr = 32'h8; bus_b.mem_rdata = 32'h0;
        @(negedge clk);
        chk("zw n stall",  32'(bus_b.stall),  32'd1);
        chk("zw n mem_en", 32'(bus_b.mem_en), 32'd0);
        @(posedge clk); #1;
        bus_b.mem_rdata = 32'h1234;
        @(negedge clk);
        chk("zw access mem_en",  32'(bus_b.mem_en),  32'd1);
        chk("zw access addr",    bus_b.mem_addr,     32'h8);
        chk("zw access mem_wr",  32'(bus_b.mem_wr),  32'd0);
        chk("zw access d_ready", 32'(bus_b.d_ready), 32'd0);
        @(posedge clk); #1;
        bus_b.mem_rdata = 32'h0;
        @(negedge clk);
        chk("zw n+2 d_ready", 32'(bus_b.d_ready), 32'd1);
        chk("zw n+2 d_rdata", bus_b.d_rdata,      32'h1234);
        chk("zw n+2 mem_en",  32'(bus_b.mem_en),  32'd0);
        chk("zw n+2 stall",   32'(bus_b.stall),   32'd0);
        bus_b.d_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("zw n+3 d_ready", 32'(bus_b.d_ready), 32'd0);
        chk("zw n+3 d_rdata", bus_b.d_rdata,      32'h1234);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified memory between the pipelined MIPS core's instruction-fetch port and its MEM-stage data port. It serialises fetch and load/store accesses with a fixed, parameterised wait-state count and returns read data with a one-cycle ready pulse. It drives a pipeline `stall` for as long as any requester is waiting. The block sits between the core's `inst_addr`/`inst` and `data_addr`/`data_out`/`data_wr`/`data_in` ports and the memory macro. Data accesses normally win arbitration, and a fairness counter bounds instruction-fetch starvation.

## Interface
Parameters:
- `WAIT_CYC`, default 1: memory wait states; range 0..15. Each access holds the memory for `WAIT_CYC+1` cycles.
- `MAX_DBURST`, default 4: consecutive data grants allowed while a fetch is pending; range 1..15.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held until `if_ready`.
- `if_addr` in 32: fetch byte address.
- `if_rdata` out 32: fetched instruction, registered.
- `if_ready` out 1: one-cycle pulse; fetch complete.
- `d_req` in 1: data request; held until `d_ready`.
- `d_wr` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data, registered.
- `d_ready` out 1: one-cycle pulse; data access complete.
- `mem_en` out 1: memory access enable.
- `mem_wr` out 1: memory write strobe.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data; valid in the last ACCESS cycle.
- `stall` out 1: pipeline freeze request to the core.

## Operation
- FSM states are IDLE, ACCESS and RESP, plus a grant flag `gnt_d` (1 = data, 0 = fetch). A 4-bit wait counter `wcnt` and a 4-bit saturating fairness counter `dstreak` complete the state.
- **IDLE, no request:** stays in IDLE; `mem_en = 0`.
- **IDLE, arbitration:** grant data if `d_req & (~if_req | dstreak < MAX_DBURST)`. Otherwise grant fetch if `if_req`.
- **IDLE, on a grant:**
  - latch `mem_addr`, `mem_wdata`, `mem_wr` (= `d_wr` for data, 0 for fetch) and `gnt_d`;
  - set `mem_en = 1` and `wcnt = 0`;
  - go to ACCESS.
- **ACCESS:** `mem_en`, `mem_wr`, `mem_addr` and `mem_wdata` are held stable. `wcnt` increments each cycle.
  - When `wcnt == WAIT_CYC`: capture `mem_rdata` into `d_rdata` or `if_rdata` (per `gnt_d`; loads and fetches only, stores leave `d_rdata` unchanged).
  - On that same edge: clear `mem_en` and `mem_wr`, assert the matching ready, go to RESP.
- **RESP:** the ready output is high for exactly this cycle. Next state is IDLE, where the ready clears.
  - The requester deasserts or changes its request in the RESP cycle. A request still asserted in IDLE is a new access.
- **`dstreak` updates, applied at grant:**
  - fetch grant: clear to 0;
  - data grant with `if_req = 1`: increment, saturating at 15;
  - data grant with `if_req = 0`: clear to 0.
- **`stall` (combinational):** `(if_req & ~if_ready) | (d_req & ~d_ready)`. It is low in the RESP cycle when the only pending request is being completed.
- **Simultaneous requests:**
  - data wins unless `dstreak == MAX_DBURST`, in which case fetch wins;
  - the loser stays pending and is arbitrated in the next IDLE.
- **Requests during ACCESS or RESP:** not sampled; they wait for IDLE.
- **Request changes while granted:** an address or data change mid-access does not affect the in-flight access, because the latched values are used.
- **Reset values:**
  - state IDLE; `gnt_d = 0`; `wcnt = 0`; `dstreak = 0`;
  - `mem_en`, `mem_wr`, `if_ready`, `d_ready` = 0;
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0;
  - `stall` follows its inputs.
- **Reset mid-access:** `mem_wr` and `mem_en` drop asynchronously, the in-flight store is aborted, and no ready is issued.

## Timing
- Request first seen in IDLE at cycle n:
  - grant edge at the end of n;
  - ACCESS cycles n+1 .. n+1+WAIT_CYC;
  - ready high in cycle n+WAIT_CYC+2.
- Total latency is `WAIT_CYC+2` cycles from request to ready. Back-to-back throughput is one access per `WAIT_CYC+3` cycles, because IDLE is mandatory between accesses.
- With `WAIT_CYC = 0`, ACCESS lasts one cycle and `mem_rdata` is sampled at its end.
- `mem_*` outputs are registered and glitch-free. `stall` is combinational from `if_req`, `d_req` and the registered ready outputs.

## Test plan
- **Fetch only:** reset; `WAIT_CYC = 1`; `if_req = 1`, `if_addr = 0x40`, memory returns `0x2008000A` in the last ACCESS cycle.
  - Expect `mem_en` high for 2 cycles with `mem_addr = 0x40`.
  - Expect `if_ready` pulse at n+3 with `if_rdata = 0x2008000A`; `stall` low in that cycle.
- **Store:** `d_req = 1`, `d_wr = 1`, `d_addr = 0x100`, `d_wdata = 0xDEADBEEF`.
  - Expect `mem_wr` high for exactly `WAIT_CYC+1` cycles with stable address and data.
  - Expect a `d_ready` pulse; `d_rdata` unchanged.
- **Contention:** `if_req` and `d_req` rise in the same cycle.
  - Data is served first; the fetch is granted in the following IDLE.
  - `stall` stays high until the fetch's `if_ready`.
- **Starvation bound:** `MAX_DBURST = 4`; `if_req` held; `d_req` re-asserted after every `d_ready`.
  - Exactly 4 data grants, then a fetch grant, then `dstreak = 0`.
- **Reset mid-store:** `nrst` low during the second ACCESS cycle.
  - `mem_wr`, `mem_en` and ready drop immediately; all registers return to reset values.
  - FSM is in IDLE after `nrst` rises.
- **Zero wait:** `WAIT_CYC = 0`; a load from `0x8` returns `0x1234`.
  - Expect `d_ready` at n+2 with `d_rdata = 0x1234`.
